// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM/owner types and default limits for the unified memory arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int DEF_STARVE_LIM = 3;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating wait counter with clear, increment and limit compare
module arb_wait_counter #(
  parameter int W = 4,
  parameter int LIM = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_lim
);
  localparam logic [W-1:0] LIM_W = W'(LIM);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_lim = cnt_q == LIM_W;
  always_comb cnt_d = clr ? '0 : (inc && !at_lim) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch and data access
import arb_pkg::*;
module unified_mem_arbiter #(
  parameter int ABUS = 32,
  parameter int DBUS = 32,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [ABUS-1:0] if_addr,
  output logic [DBUS-1:0] if_rdata,
  output logic            if_valid,
  input  logic            d_re,
  input  logic            d_we,
  input  logic [ABUS-1:0] d_addr,
  input  logic [DBUS-1:0] d_wdata,
  output logic [DBUS-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ABUS-1:0] mem_addr,
  output logic [DBUS-1:0] mem_wdata,
  input  logic [DBUS-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall,
  output logic            err
);
  arb_state_t state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic if_valid_q, if_valid_d, d_valid_q, d_valid_d, err_q, err_d;
  logic [ABUS-1:0] mem_addr_q, mem_addr_d;
  logic [DBUS-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic d_any, d_grant, busy, done, starve_hit, tmo_hit, st_inc, st_clr;
  owner_t owner;
  assign d_any = d_re | d_we;
  assign d_grant = d_any & ~(if_req & starve_hit);
  assign busy = state_q != IDLE;
  assign owner = state_q == BUSY_IF ? OWN_IF : OWN_D;
  assign done = busy & (mem_ack | tmo_hit);
  assign st_inc = ~busy & d_grant & if_req;
  assign st_clr = ~busy & (d_grant ? ~if_req : if_req);
  arb_wait_counter #(.W($clog2(STARVE_LIM + 1)), .LIM(STARVE_LIM)) u_starve (
    .clk, .rst, .clr(st_clr), .inc(st_inc), .at_lim(starve_hit)
  );
  // limit is TIMEOUT-1 so the abort edge ends exactly TIMEOUT busy cycles
  arb_wait_counter #(.W($clog2(TIMEOUT)), .LIM(TIMEOUT - 1)) u_timeout (
    .clk, .rst, .clr(~busy), .inc(busy), .at_lim(tmo_hit)
  );
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    if_valid_d = done & (owner == OWN_IF);
    d_valid_d = done & (owner == OWN_D);
    err_d = err_q | (done & ~mem_ack);
    if (!busy && d_grant) begin
      state_d = BUSY_D;
      mem_req_d = 1'b1;
      mem_we_d = d_we;
      mem_addr_d = d_addr;
      mem_wdata_d = d_wdata;
    end else if (!busy && if_req) begin
      state_d = BUSY_IF;
      mem_req_d = 1'b1;
      mem_we_d = 1'b0;
      mem_addr_d = if_addr;
    end else if (done) begin
      state_d = IDLE;
      mem_req_d = 1'b0;
      mem_we_d = 1'b0;
      if (if_valid_d) if_rdata_d = mem_ack ? mem_rdata : '0;
      if (d_valid_d && !mem_we_q) d_rdata_d = mem_ack ? mem_rdata : '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      if_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q <= d_valid_d;
      err_q <= err_d;
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign d_rdata = d_rdata_q;
  assign d_valid = d_valid_q;
  assign err = err_q;
  assign stall = (if_req & ~if_valid_q) | (d_any & ~d_valid_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench for the unified memory arbiter
module tb_unified_mem_arbiter;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_t;

  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, d_re = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic if_valid, d_valid, mem_req, mem_we, stall, err;
  logic mem_ack = 1'b0, ack_en = 1'b1, stray_ack = 1'b0, req_prev = 1'b0;
  int passed = 0, total = 0;
  mem_t exp_mem[$];
  logic [31:0] exp_if[$], exp_d[$];

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic push_mem(input logic [31:0] a, input logic w, input logic [31:0] wd);
    mem_t m;
    m.addr = a;
    m.we = w;
    m.wdata = wd;
    exp_mem.push_back(m);
  endtask

  task automatic wait_valid(input bit is_d, input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cyc();
      seen = is_d ? d_valid : if_valid;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  // memory model: single-cycle ack on the first busy cycle unless disabled
  always @(negedge clk) begin
    mem_ack <= stray_ack || (ack_en && mem_req);
    mem_rdata <= (mem_addr == 32'h40) ? 32'hE3A01005 : (32'hD000_0000 ^ mem_addr);
  end

  // memory-side monitor: one expected transaction per rising mem_req
  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      if (exp_mem.size() == 0) chk("mem_unexpected_req", 32'(mem_req), 32'd0);
      else begin
        mem_t e;
        e = exp_mem.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
    req_prev <= mem_req;
  end

  // requester-side monitor
  always @(negedge clk) begin
    if (if_valid) begin
      if (exp_if.size() == 0) chk("if_unexpected_valid", 32'(if_valid), 32'd0);
      else chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (d_valid) begin
      if (exp_d.size() == 0) chk("d_unexpected_valid", 32'(d_valid), 32'd0);
      else chk("d_rdata", d_rdata, exp_d.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nd, nf, busy_cycles;
    repeat (2) cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    cyc();

    push_mem(32'h40, 1'b0, 32'h0);
    exp_if.push_back(32'hE3A01005);
    if_req = 1'b1;
    if_addr = 32'h40;
    #1 chk("fetch_stall_c0", 32'(stall), 32'd1);
    cyc();
    chk("fetch_req_c1", 32'(mem_req), 32'd1);
    chk("fetch_addr_c1", mem_addr, 32'h40);
    chk("fetch_we_c1", 32'(mem_we), 32'd0);
    chk("fetch_stall_c1", 32'(stall), 32'd1);
    cyc();
    chk("fetch_valid_c2", 32'(if_valid), 32'd1);
    chk("fetch_req_c2", 32'(mem_req), 32'd0);
    chk("fetch_stall_c2", 32'(stall), 32'd0);
    if_req = 1'b0;
    cyc();

    // fetch starves behind data until the starvation limit forces it in
    push_mem(32'h300, 1'b0, 32'h0);
    push_mem(32'h304, 1'b0, 32'h0);
    push_mem(32'h308, 1'b0, 32'h0);
    push_mem(32'h200, 1'b0, 32'h0);
    push_mem(32'h30C, 1'b0, 32'h0);
    exp_d.push_back(32'hD000_0300);
    exp_d.push_back(32'hD000_0304);
    exp_d.push_back(32'hD000_0308);
    exp_d.push_back(32'hD000_030C);
    exp_if.push_back(32'hD000_0200);
    if_req = 1'b1;
    if_addr = 32'h200;
    d_re = 1'b1;
    d_addr = 32'h300;
    nd = 0;
    nf = 0;
    for (int c = 0; c < 60 && (nd < 4 || nf < 1); c++) begin
      cyc();
      if (d_valid) begin
        nd++;
        if (nd == 4) d_re = 1'b0;
        else d_addr = d_addr + 32'd4;
      end
      if (if_valid) begin
        nf++;
        if_req = 1'b0;
      end
    end
    chk("starve_d_count", 32'(nd), 32'd4);
    chk("starve_if_count", 32'(nf), 32'd1);
    cyc();

    push_mem(32'h100, 1'b1, 32'h55);
    push_mem(32'h44, 1'b0, 32'h0);
    exp_d.push_back(32'hD000_030C);
    exp_if.push_back(32'hD000_0044);
    if_req = 1'b1;
    if_addr = 32'h44;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'h55;
    nd = 0;
    nf = 0;
    for (int c = 0; c < 40 && (nd == 0 || nf == 0); c++) begin
      cyc();
      if (d_valid) begin
        nd++;
        d_we = 1'b0;
      end
      if (if_valid) begin
        nf++;
        if_req = 1'b0;
      end
    end
    chk("simul_d_count", 32'(nd), 32'd1);
    chk("simul_if_count", 32'(nf), 32'd1);
    cyc();

    push_mem(32'h104, 1'b1, 32'hAA);
    exp_d.push_back(32'hD000_030C);
    d_re = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h104;
    d_wdata = 32'hAA;
    cyc();
    chk("dual_mem_we", 32'(mem_we), 32'd1);
    wait_valid(1'b1, "dual_done");
    d_re = 1'b0;
    d_we = 1'b0;
    cyc();

    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("stray_valids", {30'd0, if_valid, d_valid}, 32'd0);
      chk("stray_err", 32'(err), 32'd0);
    end

    push_mem(32'h500, 1'b0, 32'h0);
    exp_d.push_back(32'h0);
    ack_en = 1'b0;
    d_re = 1'b1;
    d_addr = 32'h500;
    busy_cycles = 0;
    nd = 0;
    for (int c = 0; c < 40 && nd == 0; c++) begin
      cyc();
      if (mem_req) busy_cycles++;
      if (d_valid) nd = 1;
    end
    chk("tmo_d_valid", 32'(nd), 32'd1);
    chk("tmo_busy_cycles", 32'(busy_cycles), 32'd16);
    chk("tmo_req_dropped", 32'(mem_req), 32'd0);
    chk("tmo_err_set", 32'(err), 32'd1);
    d_re = 1'b0;
    repeat (10) cyc();
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_d_rdata_hold", d_rdata, 32'd0);

    push_mem(32'h600, 1'b0, 32'h0);
    if_req = 1'b1;
    if_addr = 32'h600;
    repeat (2) cyc();
    chk("rstmid_busy", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_req_async", 32'(mem_req), 32'd0);
    chk("rstmid_err_cleared", 32'(err), 32'd0);
    if_req = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    ack_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("rstmid_no_valid", 32'(if_valid), 32'd0);
    end

    push_mem(32'h40, 1'b0, 32'h0);
    exp_if.push_back(32'hE3A01005);
    if_req = 1'b1;
    if_addr = 32'h40;
    wait_valid(1'b0, "post_rst_fetch_done");
    if_req = 1'b0;
    repeat (3) cyc();

    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("exp_if_drained", 32'(exp_if.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
